// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider: registered divided clock, tick strobe and a
// req/ack ratio-change handshake that only takes effect on a period boundary.
module clk_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic [DIV_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt, div_nxt, pend_val;
    logic             pending, pending_nxt;
    logic             clk_out_nxt, tick_nxt, ack_nxt, err_nxt, active_nxt;
    logic             wrap, capture, val_ok, apply_now, apply_pend, pend_set;

    assign wrap    = (state != IDLE) && (cnt == div_cur - DIV_W'(1));
    assign capture = div_req && !div_ack && !div_err && !pending;
    assign val_ok  = div_val >= DIV_W'(2);

    // An idle divider that is not starting can take a new ratio immediately; if en rises
    // on the same edge the first period keeps the old ratio and the request waits a wrap.
    assign apply_now  = capture && val_ok && (state == IDLE) && !en;
    assign apply_pend = pending && ((state == IDLE) || wrap);
    assign pend_set   = capture && val_ok && !apply_now;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = DRAIN;
            DRAIN:   if (en) state_nxt = RUN;
                     else if (wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        div_nxt = div_cur;
        if (apply_pend)     div_nxt = pend_val;
        else if (apply_now) div_nxt = div_val;

        cnt_nxt = '0;
        if (state != IDLE && state_nxt != IDLE && !wrap) cnt_nxt = cnt + DIV_W'(1);

        active_nxt  = (state_nxt != IDLE);
        clk_out_nxt = active_nxt && (cnt_nxt < (div_nxt >> 1));
        tick_nxt    = active_nxt && (cnt_nxt == '0);
        ack_nxt     = apply_pend || apply_now;
        err_nxt     = capture && !val_ok;

        pending_nxt = pending;
        if (pend_set)        pending_nxt = 1'b1;
        else if (apply_pend) pending_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_cur  <= DEF_DIV;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
            active   <= 1'b0;
            pending  <= 1'b0;
            pend_val <= DEF_DIV;
        end else begin
            cnt     <= cnt_nxt;
            div_cur <= div_nxt;
            clk_out <= clk_out_nxt;
            tick    <= tick_nxt;
            div_ack <= ack_nxt;
            div_err <= err_nxt;
            active  <= active_nxt;
            pending <= pending_nxt;
            if (pend_set) pend_val <= div_val;
        end
    end

endmodule
